// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game controller: state encoding, hole count and
// winner codes.
package whack_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StPlay      = 2'd2,
    StOver      = 2'd3
  } game_state_e;

  localparam int unsigned NUM_HOLES = 9;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP0   = 2'b01;
  localparam logic [1:0] WinP1   = 2'b10;
  localparam logic [1:0] WinTie  = 2'b11;

  function automatic logic [1:0] decide_winner(input logic [15:0] s0, input logic [15:0] s1);
    if (s0 > s1) return WinP0;
    if (s1 > s0) return WinP1;
    return WinTie;
  endfunction

endpackage

// File: rtl/whack_hole_finder.sv
// Combinational free-hole search: returns the first free hole scanning upward from start,
// wrapping modulo NUM_HOLES.
module whack_hole_finder
  import whack_pkg::*;
(
  input  logic [NUM_HOLES-1:0] occupancy,
  input  logic [3:0]           start,
  output logic                 found,
  output logic [3:0]           hole
);

  logic [3:0] idx;

  always_comb begin
    found = 1'b0;
    hole  = '0;
    idx   = '0;
    for (int k = 0; k < int'(NUM_HOLES); k++) begin
      idx = 4'((int'(start) + k) % int'(NUM_HOLES));
      if (!found && !occupancy[idx]) begin
        found = 1'b1;
        hole  = idx;
      end
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Two-player whack-a-mole game controller: countdown/play/over sequencing, round-robin hole
// grants and winner latch. Optional input pause is enabled by defining WHACK_PAUSE_EN.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned COUNTDOWN_S = 3,
  parameter int unsigned GAME_S      = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_btn,
  input  logic [1:0]           req,
  input  logic [3:0]           req_pos0,
  input  logic [3:0]           req_pos1,
  input  logic [NUM_HOLES-1:0] hole_release,
  input  logic [15:0]          score0,
  input  logic [15:0]          score1,
`ifdef WHACK_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [1:0]           grant,
  output logic [3:0]           grant_pos,
  output logic [NUM_HOLES-1:0] occupancy,
  output logic [1:0]           state,
  output logic [7:0]           time_left,
  output logic [1:0]           winner
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CYCLES - 1);

  game_state_e          state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [7:0]           time_q, time_d;
  logic [NUM_HOLES-1:0] occ_q, occ_d;
  logic [1:0]           grant_q, grant_d;
  logic [3:0]           gpos_q, gpos_d;
  logic [1:0]           win_q, win_d;
  logic                 rr_q, rr_d;  // player favoured when both request
  logic                 start_q;

  logic       paused, start_rise, wrap, expire;
  logic [1:0] eligible;
  logic       sel;
  logic [3:0] sel_pos, find_start, found_hole;
  logic       found;

`ifdef WHACK_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign start_rise = start_btn & ~start_q;
  assign wrap       = (tick_q == TickMax);
  assign expire     = (time_q == 8'd0) || (wrap && time_q == 8'd1);

  // A player granted last cycle sits out one cycle so its req can drop.
  assign eligible   = req & ~grant_q;
  assign sel        = (eligible == 2'b11) ? rr_q : eligible[1];
  assign sel_pos    = sel ? req_pos1 : req_pos0;
  assign find_start = (sel_pos > 4'(NUM_HOLES - 1)) ? 4'd0 : sel_pos;

  whack_hole_finder u_finder (
    .occupancy (occ_q),
    .start     (find_start),
    .found     (found),
    .hole      (found_hole)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    time_d  = time_q;
    occ_d   = occ_q & ~hole_release;
    grant_d = '0;
    gpos_d  = '0;
    win_d   = win_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          state_d = StCountdown;
          time_d  = 8'(COUNTDOWN_S);
          tick_d  = '0;
          win_d   = WinNone;
        end
      end
      StCountdown: begin
        if (!paused) begin
          if (expire) begin
            state_d = StPlay;
            time_d  = 8'(GAME_S);
            tick_d  = '0;
          end else begin
            tick_d = wrap ? '0 : tick_q + 1'b1;
            if (wrap) time_d = time_q - 8'd1;
          end
        end
      end
      StPlay: begin
        if (!paused) begin
          if (expire) begin
            state_d = StOver;
            time_d  = 8'd0;
            tick_d  = '0;
            occ_d   = '0;
            win_d   = decide_winner(score0, score1);
          end else begin
            tick_d = wrap ? '0 : tick_q + 1'b1;
            if (wrap) time_d = time_q - 8'd1;
            // Grant decision uses pre-release occupancy; the set wins over a same-edge release.
            if ((eligible != 2'b00) && found) begin
              grant_d[sel]      = 1'b1;
              gpos_d            = found_hole;
              occ_d[found_hole] = 1'b1;
              rr_d              = ~sel;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      time_q  <= '0;
      occ_q   <= '0;
      grant_q <= '0;
      gpos_q  <= '0;
      win_q   <= WinNone;
      rr_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      time_q  <= time_d;
      occ_q   <= occ_d;
      grant_q <= grant_d;
      gpos_q  <= gpos_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      start_q <= start_btn;
    end
  end

  assign grant     = grant_q;
  assign grant_pos = gpos_q;
  assign occupancy = occ_q;
  assign state     = state_q;
  assign time_left = time_q;
  assign winner    = win_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl: phase/elapsed-time game model with per-cycle compare
// plus directed literal checks of timing, arbitration, hole search, winner and reset.
module tb_whack_game_ctrl;

  localparam int T  = 4;
  localparam int CD = 2;
  localparam int G  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_btn;
  logic [1:0]  req;
  logic [3:0]  req_pos0, req_pos1;
  logic [8:0]  hole_release;
  logic [15:0] score0, score1;
  logic [1:0]  grant;
  logic [3:0]  grant_pos;
  logic [8:0]  occupancy;
  logic [1:0]  state;
  logic [7:0]  time_left;
  logic [1:0]  winner;

  int tests = 0;
  int fails = 0;

  whack_game_ctrl #(
    .TICK_CYCLES (T),
    .COUNTDOWN_S (CD),
    .GAME_S      (G)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .req          (req),
    .req_pos0     (req_pos0),
    .req_pos1     (req_pos1),
    .hole_release (hole_release),
    .score0       (score0),
    .score1       (score1),
    .grant        (grant),
    .grant_pos    (grant_pos),
    .occupancy    (occupancy),
    .state        (state),
    .time_left    (time_left),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase (0 idle,1 countdown,2 play,3 over) plus cycles elapsed in the timed phase.
  int         m_state = 0, m_elapsed = 0, m_time = 0, m_fav = 0;
  logic [1:0] m_grant = '0, m_winner = '0;
  logic [3:0] m_gpos = '0;
  logic [8:0] m_occ = '0;
  bit         m_start_prev = 1'b0;

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_time = 0; m_fav = 0;
    m_grant = '0; m_gpos = '0; m_occ = '0; m_winner = '0; m_start_prev = 1'b0;
  endtask

  task automatic model_step();
    bit         rise, found;
    logic [1:0] cand, g;
    logic [3:0] gp, pos;
    logic [8:0] nocc;
    int         p, start, h;
    rise = start_btn && !m_start_prev;
    g = '0; gp = '0; h = 0;
    nocc = m_occ & ~hole_release;
    case (m_state)
      0: if (rise) begin m_state = 1; m_elapsed = 0; end
      1: if (m_elapsed + 1 == CD * T) begin m_state = 2; m_elapsed = 0; end
         else m_elapsed++;
      2: if (m_elapsed + 1 == G * T) begin
           m_state = 3; nocc = '0;
           m_winner = (score0 > score1) ? 2'b01 : (score1 > score0) ? 2'b10 : 2'b11;
         end else begin
           m_elapsed++;
           cand = req & ~m_grant;
           if (cand != 2'b00) begin
             p = (cand == 2'b11) ? m_fav : (cand[1] ? 1 : 0);
             pos = (p == 1) ? req_pos1 : req_pos0;
             start = (pos > 8) ? 0 : int'(pos);
             found = 1'b0;
             for (int k = 0; k < 9; k++)
               if (!found && !m_occ[(start + k) % 9]) begin found = 1'b1; h = (start + k) % 9; end
             if (found) begin
               g[p] = 1'b1; gp = 4'(h); nocc[h] = 1'b1; m_fav = 1 - p;
             end
           end
         end
      default: if (rise) begin m_state = 1; m_elapsed = 0; m_winner = '0; end
    endcase
    m_grant = g; m_gpos = gp; m_occ = nocc; m_start_prev = start_btn;
    m_time = (m_state == 1) ? CD - m_elapsed / T : (m_state == 2) ? G - m_elapsed / T : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("state", {30'd0, state}, m_state);
    chk("time_left", {24'd0, time_left}, m_time);
    chk("grant", {30'd0, grant}, {30'd0, m_grant});
    if (m_grant != 2'b00) chk("grant_pos", {28'd0, grant_pos}, {28'd0, m_gpos});
    chk("occupancy", {23'd0, occupancy}, {23'd0, m_occ});
    chk("winner", {30'd0, winner}, {30'd0, m_winner});
  end

  task automatic wait_state(input logic [1:0] target, input int limit);
    int n = 0;
    while (state !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", {30'd0, state}, {30'd0, target});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start_btn = 1'b0; req = '0; req_pos0 = '0; req_pos1 = '0;
    hole_release = '0; score0 = 16'd300; score1 = 16'd300;
    repeat (2) @(negedge clk);
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_occ", {23'd0, occupancy}, 0);
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_time", {24'd0, time_left}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Game 1: countdown length, arbitration, search from out-of-range pos, tie.
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    n = 0;
    while (state == 2'd1 && n < 40) begin n++; @(negedge clk); end
    chk("countdown_len", n, 8);
    chk("play_entry_time", {24'd0, time_left}, 3);
    req = 2'b11; req_pos0 = 4'd4; req_pos1 = 4'd4;
    @(negedge clk);
    chk("rr_first_grant", {30'd0, grant}, 2'b01);
    chk("rr_first_pos", {28'd0, grant_pos}, 4);
    req = 2'b10;
    @(negedge clk);
    chk("rr_second_grant", {30'd0, grant}, 2'b10);
    chk("rr_second_pos", {28'd0, grant_pos}, 5);
    req = 2'b01; req_pos0 = 4'd12;
    @(negedge clk);
    chk("oor_grant", {30'd0, grant}, 2'b01);
    chk("oor_pos", {28'd0, grant_pos}, 0);
    req = 2'b00; hole_release = 9'h010;
    n = 4;
    @(negedge clk);
    hole_release = '0;
    while (state == 2'd2 && n < 40) begin n++; @(negedge clk); end
    chk("play_len", n, 12);
    chk("tie_winner", {30'd0, winner}, 2'b11);
    chk("over_occ", {23'd0, occupancy}, 0);

    // Game 2: restart from OVER, start ignored in countdown, full board, release+grant.
    score0 = 16'd450; score1 = 16'd200;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("restart_state", {30'd0, state}, 1);
    chk("restart_winner", {30'd0, winner}, 0);
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    wait_state(2'd2, 20);
    req = 2'b10; req_pos0 = 4'd0; req_pos1 = 4'd0;
    @(negedge clk);
    req = 2'b11;
    repeat (8) @(negedge clk);
    chk("full_occ", {23'd0, occupancy}, 9'h1FF);
    req = 2'b01; hole_release = 9'h004;
    @(negedge clk);
    hole_release = '0;
    chk("full_no_grant", {30'd0, grant}, 0);
    chk("release_occ", {23'd0, occupancy}, 9'h1FB);
    @(negedge clk);
    chk("refill_grant", {30'd0, grant}, 2'b01);
    chk("refill_pos", {28'd0, grant_pos}, 2);
    req = 2'b00;
    wait_state(2'd3, 20);
    chk("p0_winner", {30'd0, winner}, 2'b01);
    chk("p0_over_occ", {23'd0, occupancy}, 0);

    // Game 3: reset in the middle of play with both players requesting.
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    wait_state(2'd2, 20);
    req = 2'b11; req_pos0 = 4'd8; req_pos1 = 4'd8;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {30'd0, state}, 0);
    chk("midrst_grant", {30'd0, grant}, 0);
    chk("midrst_occ", {23'd0, occupancy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_grant", {30'd0, grant}, 0);
    req = 2'b00;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
WHACK_GAME_CTRL -- requirements
Module: whack_game_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 50_000_000, clock cycles per one-second tick.
REQ-002 Parameter COUNTDOWN_S, default 3, pre-game countdown length in seconds.
REQ-003 Parameter GAME_S, default 60, play-phase length in seconds, 1..255.
REQ-004 Port clk  in  1  sole clock, all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port start_btn  in  1  level start request, edge-detected internally.
REQ-007 Port req  in  2  per-player mole-spawn request, level, held until granted.
REQ-008 Port req_pos0 / req_pos1  in  4 each  requested hole index for player 0 / 1.
REQ-009 Port release  in  9  one bit per hole, frees that hole (mole hit or timed out).
REQ-010 Port score0 / score1  in  16 each  player scores, sampled at game end.
REQ-011 Port grant  out  2  one-hot, one-cycle grant pulse.
REQ-012 Port grant_pos  out  4  hole assigned with grant, valid only while grant!=0.
REQ-013 Port occupancy  out  9  registered hole-reservation bitmap.
REQ-014 Port state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3.
REQ-015 Port time_left  out  8  seconds remaining in current timed state.
REQ-016 Port winner  out  2  01 = player 0, 10 = player 1, 11 = tie, 00 = undecided.

Function
REQ-017 The FSM SHALL move IDLE->COUNTDOWN on a start_btn rising edge, loading time_left=COUNTDOWN_S.
REQ-018 A tick counter SHALL count 0..TICK_CYCLES-1 in COUNTDOWN/PLAY; at wrap time_left decrements.
REQ-019 When time_left reaches 0 in COUNTDOWN, the next cycle SHALL enter PLAY with time_left=GAME_S and tick counter cleared.
REQ-020 When time_left reaches 0 in PLAY, the next cycle SHALL enter OVER, clear occupancy, and latch winner from score0/score1 that cycle.
REQ-021 In OVER a start_btn rising edge SHALL enter COUNTDOWN, clearing winner; start_btn in COUNTDOWN/PLAY SHALL be ignored.
REQ-022 Grants SHALL be issued only in PLAY, at most one per cycle, registered: request visible at edge N gives grant at edge N+1.
REQ-023 Simultaneous requests SHALL be resolved round-robin: the player not granted last wins; pointer favours player 0 after reset.
REQ-024 Requested hole free and <=8 SHALL be granted as-is; otherwise the first free hole searching (pos+1) mod 9 upward SHALL be assigned; out-of-range pos SHALL start search at 0.
REQ-025 If all 9 holes are occupied no grant SHALL be issued and req stays pending.
REQ-026 A granted hole SHALL set its occupancy bit on the grant edge; release clears bits on the next edge.
REQ-027 Release and grant in the same cycle: grant SHALL use pre-release occupancy; both updates apply on that edge; release of the granted hole loses to the set.
REQ-028 A granted requester SHALL not be granted again in the cycle directly after its grant (req deassert slack).

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, grant=0, grant_pos=0, occupancy=0, time_left=0, winner=0, tick counter=0, round-robin pointer=player 0, start edge register=0.
REQ-030 Reset asserted mid-PLAY SHALL drop any pending grant; no output pulses on the release edge.

Configuration
REQ-031 Macro WHACK_PAUSE_EN: when defined, adds input pause (1 bit); while high in COUNTDOWN/PLAY the tick counter and grants freeze, state holds. When undefined, no pause port exists and timing is uninterrupted.

Structure
REQ-032 Shared package whack_pkg SHALL hold the state encoding, NUM_HOLES=9, winner codes.
REQ-033 Free-hole search SHALL be a sub-module whack_hole_finder (combinational: occupancy, start pos -> found, hole).

Verification (TICK_CYCLES=4, COUNTDOWN_S=2, GAME_S=3)
REQ-034 start_btn pulse in IDLE -> COUNTDOWN 8 cycles, then PLAY time_left=3, OVER after 12 further cycles.
REQ-035 PLAY, req=11 both pos=4, occupancy=0 -> grant=01 pos 4; with req still 10 pos 4, next-but-one cycle -> grant=10 pos 5.
REQ-036 occupancy=1_1111_1111, req=01 -> no grant; release[2]=1 -> grant=01 pos 2 two cycles later.
REQ-037 req_pos0=12 in PLAY, holes 0 free -> grant pos 0.
REQ-038 score0=300, score1=300 at PLAY end -> winner=11, occupancy=0; score0=450, score1=200 -> winner=01.
REQ-039 rst_n low mid-PLAY with req=11 -> immediate IDLE, grant=0, occupancy=0.
